// File: rtl/silife_spi_tx.sv
// Mode-0 SPI transmit engine for the MAX7219 path: shifts one register word
// per transfer and reports busy/done so the controller can sequence chip-select.
module silife_spi_tx #(
    parameter int unsigned WORD_BITS = 16,
    parameter int unsigned DIVIDER   = 1,
    parameter int unsigned LSB_FIRST = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_BITS-1:0] i_word,
    input  logic                 i_start,
    output logic                 o_sck,
    output logic                 o_mosi,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int unsigned CNT_W = $clog2(WORD_BITS + 1);
    localparam int unsigned DIV_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVIDER - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_HOLD
    } state_t;

    state_t               state, state_nxt;
    logic [WORD_BITS-1:0] shift, shift_nxt, shift_adv;
    logic [CNT_W-1:0]     bit_cnt, bit_nxt, bit_dec;
    logic [DIV_W-1:0]     div_cnt, div_nxt;
    logic                 sck_nxt, mosi_nxt, busy_nxt, done_nxt;

    // Bit that sits at the output end of the shifter for the chosen order.
    function automatic logic lead_bit(input logic [WORD_BITS-1:0] v);
        return (LSB_FIRST != 0) ? v[0] : v[WORD_BITS-1];
    endfunction

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            o_sck   <= 1'b0;
            o_mosi  <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            shift   <= shift_nxt;
            bit_cnt <= bit_nxt;
            div_cnt <= div_nxt;
            o_sck   <= sck_nxt;
            o_mosi  <= mosi_nxt;
            o_busy  <= busy_nxt;
            o_done  <= done_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        shift_nxt = shift;
        bit_nxt   = bit_cnt;
        div_nxt   = div_cnt;
        sck_nxt   = o_sck;
        mosi_nxt  = o_mosi;
        busy_nxt  = o_busy;
        done_nxt  = 1'b0;
        bit_dec   = bit_cnt - CNT_W'(1);
        shift_adv = (LSB_FIRST != 0) ? (shift >> 1) : (shift << 1);

        case (state)
            ST_IDLE: begin
                sck_nxt  = 1'b0;
                mosi_nxt = 1'b0;
                busy_nxt = 1'b0;
                if (i_start) begin
                    shift_nxt = i_word;
                    mosi_nxt  = lead_bit(i_word);
                    busy_nxt  = 1'b1;
                    bit_nxt   = CNT_FULL;
                    div_nxt   = '0;
                    state_nxt = ST_LOW;
                end
            end
            ST_LOW: begin
                sck_nxt = 1'b0;
                if (div_cnt == DIV_LAST) begin
                    sck_nxt   = 1'b1;
                    div_nxt   = '0;
                    state_nxt = ST_HIGH;
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            ST_HIGH: begin
                sck_nxt = 1'b1;
                if (div_cnt == DIV_LAST) begin
                    sck_nxt = 1'b0;
                    div_nxt = '0;
                    bit_nxt = bit_dec;
                    // Data only moves on the falling edge, giving full-phase setup/hold.
                    if (bit_dec != '0) begin
                        shift_nxt = shift_adv;
                        mosi_nxt  = lead_bit(shift_adv);
                        state_nxt = ST_LOW;
                    end else begin
                        mosi_nxt  = 1'b0;
                        state_nxt = ST_HOLD;
                    end
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            ST_HOLD: begin
                sck_nxt = 1'b0;
                if (div_cnt == DIV_LAST) begin
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    div_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_silife_spi_tx.sv
// Bench for silife_spi_tx: three parameterisations checked every cycle against
// a timing-formula model, plus literal checks of captured words and durations.
module tb_silife_spi_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [3];
    logic        start [3];
    logic [15:0] word  [3];
    logic        sck   [3];
    logic        mosi  [3];
    logic        busy  [3];
    logic        done  [3];

    silife_spi_tx #(.WORD_BITS(16), .DIVIDER(1), .LSB_FIRST(0)) u0 (
        .clk(clk), .reset_n(rst_n[0]), .i_word(word[0]), .i_start(start[0]),
        .o_sck(sck[0]), .o_mosi(mosi[0]), .o_busy(busy[0]), .o_done(done[0]));

    silife_spi_tx #(.WORD_BITS(16), .DIVIDER(3), .LSB_FIRST(0)) u1 (
        .clk(clk), .reset_n(rst_n[1]), .i_word(word[1]), .i_start(start[1]),
        .o_sck(sck[1]), .o_mosi(mosi[1]), .o_busy(busy[1]), .o_done(done[1]));

    silife_spi_tx #(.WORD_BITS(8), .DIVIDER(2), .LSB_FIRST(1)) u2 (
        .clk(clk), .reset_n(rst_n[2]), .i_word(word[2][7:0]), .i_start(start[2]),
        .o_sck(sck[2]), .o_mosi(mosi[2]), .o_busy(busy[2]), .o_done(done[2]));

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int pw(input int i);
        return (i == 2) ? 8 : 16;
    endfunction
    function automatic int pd(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 2);
    endfunction
    function automatic bit pl(input int i);
        return (i == 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected {sck, mosi, busy, done} a given number of cycles after the accepting edge.
    function automatic logic [3:0] model_out(input int w, input int d, input bit lsb,
                                             input logic [15:0] wd, input int phase);
        logic [3:0] r;
        int n;
        r = 4'b0;
        if (phase < 0) return r;
        if (phase < 2 * w * d) begin
            n = phase / (2 * d);
            r[3] = ((phase / d) % 2) == 1;
            r[2] = lsb ? wd[n] : wd[w - 1 - n];
        end
        r[1] = phase < (2 * w + 1) * d;
        r[0] = phase == (2 * w + 1) * d;
        return r;
    endfunction

    // Reference model, advanced at every rising edge from the sampled inputs.
    bit          act  [3];
    int          kst  [3];
    logic [15:0] mw   [3];
    logic [3:0]  expv [3];
    int          cyc = 0;

    initial begin
        for (int i = 0; i < 3; i++) begin
            act[i] = 1'b0; kst[i] = 0; mw[i] = '0; expv[i] = 4'b0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (!rst_n[i]) begin
                    act[i] = 1'b0;
                end else if (!expv[i][1] && start[i]) begin
                    act[i] = 1'b1;
                    kst[i] = cyc;
                    mw[i]  = word[i];
                end
                expv[i] = act[i] ? model_out(pw(i), pd(i), pl(i), mw[i], cyc - kst[i]) : 4'b0;
            end
        end
    end

    // Per-cycle compare plus a receiver that captures mosi on sck rising edges.
    logic        psck  [3];
    logic        pbusy [3];
    logic [15:0] cap   [3];
    logic [15:0] lcap  [3];
    int          rises [3];
    int          lrises[3];
    int          bcnt  [3];
    int          lbusy [3];
    int          dcount[3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            psck[i] = 1'b0; pbusy[i] = 1'b0; cap[i] = '0; lcap[i] = '0;
            rises[i] = 0; lrises[i] = 0; bcnt[i] = 0; lbusy[i] = 0; dcount[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("u%0d_outs_cyc%0d", i, cyc),
                      32'({sck[i], mosi[i], busy[i], done[i]}), 32'(expv[i]));
                if (busy[i] && !pbusy[i]) begin
                    cap[i] = '0; rises[i] = 0; bcnt[i] = 0;
                end
                if (busy[i]) bcnt[i]++;
                if (sck[i] && !psck[i]) begin
                    rises[i]++;
                    if (pl(i)) cap[i] = (cap[i] >> 1) | (16'(mosi[i]) << (pw(i) - 1));
                    else       cap[i] = {cap[i][14:0], mosi[i]};
                end
                if (done[i]) begin
                    lcap[i] = cap[i]; lrises[i] = rises[i]; lbusy[i] = bcnt[i];
                    dcount[i]++;
                end
                psck[i] = sck[i]; pbusy[i] = busy[i];
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int i, input int budget);
        int d0;
        bit got;
        d0  = dcount[i];
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            #1;
            if (dcount[i] != d0) got = 1'b1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL u%0d_done_timeout: got no done in %0d cycles, expected a done pulse", i, budget);
        end
    endtask

    task automatic send(input int i, input logic [15:0] w);
        word[i]  = w;
        start[i] = 1'b1;
        tick(1);
        start[i] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        logic [15:0] w;
        logic [31:0] mask;
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; start[i] = 1'b0; word[i] = '0;
        end
        start[0] = 1'b1;
        word[0]  = 16'h0C01;

        // Reset held with start asserted: everything stays quiet.
        repeat (3) begin
            tick(1);
            check("reset_outs_u0", 32'({sck[0], mosi[0], busy[0], done[0]}), 32'h0);
        end
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        tick(1);
        check("start_after_reset_busy", 32'(busy[0]), 32'h1);
        check("start_after_reset_mosi", 32'(mosi[0]), 32'h0);
        start[0] = 1'b0;
        wait_done(0, 60);
        check("default_word", 32'(lcap[0]), 32'h0C01);
        check("default_rises", 32'(lrises[0]), 32'd16);
        check("default_busy_len", 32'(lbusy[0]), 32'd33);

        // Slower sck.
        send(1, 16'hA55A);
        wait_done(1, 200);
        check("div3_word", 32'(lcap[1]), 32'hA55A);
        check("div3_rises", 32'(lrises[1]), 32'd16);
        check("div3_busy_len", 32'(lbusy[1]), 32'd99);

        // Start and word change while busy are ignored.
        send(0, 16'h0F00);
        tick(9);
        send(0, 16'hFFFF);
        wait_done(0, 60);
        check("busy_start_word", 32'(lcap[0]), 32'h0F00);
        d = dcount[0];
        tick(5);
        check("busy_start_single_done", 32'(dcount[0]), 32'(d));
        check("busy_start_idle_after", 32'(busy[0]), 32'h0);

        // Level start: next word one idle cycle after done.
        word[0]  = 16'h1234;
        start[0] = 1'b1;
        wait_done(0, 60);
        check("held_first_word", 32'(lcap[0]), 32'h1234);
        check("held_gap_idle", 32'(busy[0]), 32'h0);
        word[0] = 16'h5678;
        tick(1);
        check("held_restart_busy", 32'(busy[0]), 32'h1);
        start[0] = 1'b0;
        wait_done(0, 60);
        check("held_second_word", 32'(lcap[0]), 32'h5678);

        // LSB-first byte instance.
        send(2, 16'h0081);
        wait_done(2, 100);
        check("lsb_word_81", 32'(lcap[2]), 32'h81);
        check("lsb_rises", 32'(lrises[2]), 32'd8);
        check("lsb_busy_len", 32'(lbusy[2]), 32'd34);
        send(2, 16'h0001);
        wait_done(2, 100);
        check("lsb_word_01", 32'(lcap[2]), 32'h01);

        // Reset in the middle of a word.
        send(0, 16'hFFFF);
        tick(11);
        rst_n[0] = 1'b0;
        tick(1);
        check("midreset_outs", 32'({sck[0], mosi[0], busy[0], done[0]}), 32'h0);
        rst_n[0] = 1'b1;
        d = dcount[0];
        tick(40);
        check("midreset_no_done", 32'(dcount[0]), 32'(d));
        send(0, 16'h3C3C);
        wait_done(0, 60);
        check("midreset_fresh_word", 32'(lcap[0]), 32'h3C3C);
        check("midreset_fresh_rises", 32'(lrises[0]), 32'd16);

        // Random words with start/word noise during the transfer.
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < 3; i++) begin
                w    = 16'($urandom);
                mask = (32'h1 << pw(i)) - 32'h1;
                send(i, w);
                for (int c = 0; c < 20; c++) begin
                    start[i] = 1'($urandom_range(0, 1));
                    word[i]  = 16'($urandom);
                    tick(1);
                end
                start[i] = 1'b0;
                wait_done(i, 200);
                check($sformatf("rand_u%0d_word_it%0d", i, it), 32'(lcap[i]), 32'(w) & mask);
            end
        end

        tick(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
